// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit controller.
// FSM state encoding, RISC-V funct3 access-size codes, the default memory
// timeout and the access-legality helper used by the lane steering logic.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

    // An access is illegal when funct3 is unused, when a store asks for an
    // unsigned size, or when a halfword/word is not naturally aligned.
    function automatic logic is_illegal(input logic       i_we,
                                        input logic [2:0] i_funct3,
                                        input logic [1:0] i_addr_lo);
        logic w_bad;
        w_bad = 1'b1;
        case (i_funct3)
            F3_B:    w_bad = 1'b0;
            F3_BU:   w_bad = i_we;
            F3_H:    w_bad = i_addr_lo[0];
            F3_HU:   w_bad = i_we | i_addr_lo[0];
            F3_W:    w_bad = |i_addr_lo;
            default: w_bad = 1'b1;
        endcase
        return w_bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for the load/store unit.
// Produces byte enables and replicated store data for the memory command,
// and selects plus sign/zero-extends load data returned by memory.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_we,
    input  logic [2:0]       i_funct3,
    input  logic [1:0]       i_addr_lo,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [WIDTH-1:0] i_rdata,
    output logic [3:0]       o_be,
    output logic [WIDTH-1:0] o_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_illegal
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte    = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half    = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];
    assign o_illegal = is_illegal(i_we, i_funct3, i_addr_lo);

    // Byte enables follow the access size shifted to the addressed lane; store data is replicated across lanes.
    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        case (i_funct3)
            F3_B, F3_BU: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {(WIDTH/8){i_wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                o_be    = 4'b0011 << i_addr_lo;
                o_wdata = {(WIDTH/16){i_wdata[15:0]}};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
            end
        endcase
    end

    // Load data is taken from the addressed lane and extended according to the signedness of funct3.
    always_comb begin
        o_rdata = i_rdata;
        case (i_funct3)
            F3_B:    o_rdata = {{(WIDTH-8){w_byte[7]}}, w_byte};
            F3_BU:   o_rdata = {{(WIDTH-8){1'b0}}, w_byte};
            F3_H:    o_rdata = {{(WIDTH-16){w_half[15]}}, w_half};
            F3_HU:   o_rdata = {{(WIDTH-16){1'b0}}, w_half};
            default: o_rdata = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller between a core request port and a
// grant/rvalid memory port. Define LSU_TIMEOUT_EN to add a watchdog that
// ends a transaction with an error after TIMEOUT_CYCLES cycles without a
// grant or a memory response.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic             i_req_we,
    input  logic [2:0]       i_req_funct3,
    input  logic [WIDTH-1:0] i_req_addr,
    input  logic [WIDTH-1:0] i_req_wdata,
    output logic             o_rsp_valid,
    output logic [WIDTH-1:0] o_rsp_rdata,
    output logic             o_rsp_err,
    output logic             o_mem_req,
    input  logic             i_mem_gnt,
    output logic             o_mem_we,
    output logic [WIDTH-1:0] o_mem_addr,
    output logic [3:0]       o_mem_be,
    output logic [WIDTH-1:0] o_mem_wdata,
    input  logic             i_mem_rvalid,
    input  logic [WIDTH-1:0] i_mem_rdata,
    output logic             o_busy
);

    lsu_state_e       r_state;
    logic             r_we;
    logic [2:0]       r_funct3;
    logic [1:0]       r_addr_lo;
    logic             r_illegal;
    logic             r_req_ready;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_rdata;
    logic             r_rsp_err;
    logic             r_mem_req;
    logic             r_mem_we;
    logic [WIDTH-1:0] r_mem_addr;
    logic [3:0]       r_mem_be;
    logic [WIDTH-1:0] r_mem_wdata;
    logic             r_busy;

    logic             w_in_idle;
    logic             w_accept;
    logic             w_sel_we;
    logic [2:0]       w_sel_funct3;
    logic [1:0]       w_sel_addr_lo;
    logic [3:0]       w_be;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_load_data;
    logic             w_illegal;
    logic             w_timeout;

    assign w_in_idle = (r_state == IDLE);
    assign w_accept  = w_in_idle && i_req_valid && r_req_ready;

    // The single aligner sees the live request while idle (to build the
    // memory command) and the latched request afterwards (to extend load data).
    assign w_sel_we      = w_in_idle ? i_req_we          : r_we;
    assign w_sel_funct3  = w_in_idle ? i_req_funct3      : r_funct3;
    assign w_sel_addr_lo = w_in_idle ? i_req_addr[1:0]   : r_addr_lo;

    lsu_align #(
        .WIDTH (WIDTH)
    ) u_align (
        .i_we      (w_sel_we),
        .i_funct3  (w_sel_funct3),
        .i_addr_lo (w_sel_addr_lo),
        .i_wdata   (i_req_wdata),
        .i_rdata   (i_mem_rdata),
        .o_be      (w_be),
        .o_wdata   (w_wdata),
        .o_rdata   (w_load_data),
        .o_illegal (w_illegal)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] r_tmo_cnt;

    assign w_timeout = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // Watchdog restarts on entry to REQ and WAIT and counts every cycle spent waiting there.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tmo_cnt <= '0;
        end else if (w_accept || (r_state == REQ && i_mem_gnt)) begin
            r_tmo_cnt <= '0;
        end else if (r_state == REQ || r_state == WAIT) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Transaction FSM; every core- and memory-facing output is a register updated here.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_funct3    <= '0;
            r_addr_lo   <= '0;
            r_illegal   <= 1'b0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_rsp_valid <= 1'b0;
                    if (w_accept) begin
                        r_state     <= REQ;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_we        <= i_req_we;
                        r_funct3    <= i_req_funct3;
                        r_addr_lo   <= i_req_addr[1:0];
                        r_illegal   <= w_illegal;
                        r_mem_req   <= !w_illegal;
                        if (!w_illegal) begin
                            r_mem_we    <= i_req_we;
                            r_mem_addr  <= {i_req_addr[WIDTH-1:2], 2'b00};
                            r_mem_be    <= w_be;
                            r_mem_wdata <= w_wdata;
                        end
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                REQ: begin
                    if (r_illegal) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                    end else if (i_mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_state   <= WAIT;
                    end else if (w_timeout) begin
                        r_mem_req   <= 1'b0;
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                    end
                end
                WAIT: begin
                    if (i_mem_rvalid) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_we ? '0 : w_load_data;
                        r_rsp_err   <= 1'b0;
                    end else if (w_timeout) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                    end
                end
                RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                    r_busy      <= 1'b0;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_req_ready = r_req_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_be    = r_mem_be;
    assign o_mem_wdata = r_mem_wdata;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: scoreboard bench for lsu_ctrl. Directed requests push their
// expected memory command and response into queues; a monitor pops and
// compares whenever the DUT raises mem_req or rsp_valid. Honours
// LSU_TIMEOUT_EN for the stalled-grant scenario.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic        reqWe = 1'b0;
    logic [2:0]  reqFunct3 = 3'b000;
    logic [31:0] reqAddr = '0;
    logic [31:0] reqWdata = '0;
    logic        rspValid;
    logic [31:0] rspRdata;
    logic        rspErr;
    logic        memReq;
    logic        memGnt = 1'b0;
    logic        memWe;
    logic [31:0] memAddr;
    logic [3:0]  memBe;
    logic [31:0] memWdata;
    logic        memRvalid = 1'b0;
    logic [31:0] memRdata = '0;
    logic        busy;

    typedef struct {
        int          id;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        err;
        int          cycle;
    } rsp_t;

    cmd_t cmdQ[$];
    rsp_t rspQ[$];
    cmd_t expCmd;
    rsp_t expRsp;

    int compared = 0;
    int mismatched = 0;
    int cycleCount = 0;

    logic        memEnable = 1'b1;
    int          gntDelay = 0;
    int          rvDelay = 0;
    logic [31:0] memData = '0;
    logic        prevMemReq = 1'b0;

    lsu_ctrl #(
        .WIDTH          (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .i_clk        (clock),
        .i_rst_n      (resetN),
        .i_req_valid  (reqValid),
        .o_req_ready  (reqReady),
        .i_req_we     (reqWe),
        .i_req_funct3 (reqFunct3),
        .i_req_addr   (reqAddr),
        .i_req_wdata  (reqWdata),
        .o_rsp_valid  (rspValid),
        .o_rsp_rdata  (rspRdata),
        .o_rsp_err    (rspErr),
        .o_mem_req    (memReq),
        .i_mem_gnt    (memGnt),
        .o_mem_we     (memWe),
        .o_mem_addr   (memAddr),
        .o_mem_be     (memBe),
        .o_mem_wdata  (memWdata),
        .i_mem_rvalid (memRvalid),
        .i_mem_rdata  (memRdata),
        .o_busy       (busy)
    );

    // Free-running clock
    always #5 clock = ~clock;

    // Cycle counter used to check response latency
    always @(posedge clock) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic failEvent(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: event seen, none expected", name);
    endtask

    // Memory model: grants after gntDelay cycles, then returns memData after rvDelay more cycles
    initial begin
        forever begin
            @(negedge clock);
            if (memEnable && memReq) begin
                repeat (gntDelay) @(negedge clock);
                memGnt = 1'b1;
                @(negedge clock);
                memGnt = 1'b0;
                repeat (rvDelay) @(negedge clock);
                memRvalid = 1'b1;
                memRdata  = memData;
                @(negedge clock);
                memRvalid = 1'b0;
                memRdata  = 32'h5555_AAAA;
            end
        end
    end

    // Monitor: compare the memory command on each rising mem_req and every rsp_valid pulse
    always @(negedge clock) begin
        if (resetN) begin
            if (memReq && !prevMemReq) begin
                if (cmdQ.size() == 0) begin
                    failEvent("unexpected mem_req");
                end else begin
                    expCmd = cmdQ.pop_front();
                    checkOutput($sformatf("vec%0d mem_we", expCmd.id), {31'b0, memWe}, {31'b0, expCmd.we});
                    checkOutput($sformatf("vec%0d mem_addr", expCmd.id), memAddr, expCmd.addr);
                    checkOutput($sformatf("vec%0d mem_be", expCmd.id), {28'b0, memBe}, {28'b0, expCmd.be});
                    checkOutput($sformatf("vec%0d mem_wdata", expCmd.id), memWdata, expCmd.wdata);
                end
            end
            if (rspValid) begin
                if (rspQ.size() == 0) begin
                    failEvent("unexpected rsp_valid");
                end else begin
                    expRsp = rspQ.pop_front();
                    checkOutput($sformatf("vec%0d rsp_rdata", expRsp.id), rspRdata, expRsp.rdata);
                    checkOutput($sformatf("vec%0d rsp_err", expRsp.id), {31'b0, rspErr}, {31'b0, expRsp.err});
                    checkOutput($sformatf("vec%0d rsp_cycle", expRsp.id), cycleCount, expRsp.cycle);
                end
            end
        end
        prevMemReq = memReq;
    end

    // Issue one request; lat counts cycles from the accept cycle (0) to the rsp_valid cycle
    task automatic applyStimulus(input int id, input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] mdata, input int gd, input int rd,
                                 input logic hasCmd, input logic [3:0] be, input logic [31:0] cmdWdata,
                                 input logic hasRsp, input logic [31:0] rdata, input logic err,
                                 input int lat);
        cmd_t c;
        rsp_t r;
        int waited;
        waited = 0;
        @(negedge clock);
        while (!reqReady && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        if (!reqReady) begin
            failEvent($sformatf("vec%0d req_ready never rose", id));
        end
        gntDelay = gd;
        rvDelay  = rd;
        memData  = mdata;
        if (hasCmd) begin
            c.id = id; c.we = we; c.addr = {addr[31:2], 2'b00}; c.be = be; c.wdata = cmdWdata;
            cmdQ.push_back(c);
        end
        if (hasRsp) begin
            r.id = id; r.rdata = rdata; r.err = err; r.cycle = cycleCount + lat;
            rspQ.push_back(r);
        end
        reqValid  = 1'b1;
        reqWe     = we;
        reqFunct3 = f3;
        reqAddr   = addr;
        reqWdata  = wdata;
        @(posedge clock);
        #1;
        reqValid = 1'b0;
        if (hasRsp) begin
            waited = 0;
            while (rspQ.size() != 0 && waited < 60) begin
                @(negedge clock);
                waited++;
            end
            if (rspQ.size() != 0) begin
                failEvent($sformatf("vec%0d response never arrived", id));
                rspQ.delete();
            end
        end
    endtask

    // Watchdog so the bench can never hang
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus
    initial begin
        $display("[TB] lsu_ctrl scoreboard bench starting");
        repeat (3) @(negedge clock);
        checkOutput("reset req_ready", {31'b0, reqReady}, 32'd0);
        checkOutput("reset busy", {31'b0, busy}, 32'd0);
        checkOutput("reset rsp_valid", {31'b0, rspValid}, 32'd0);
        checkOutput("reset mem_req", {31'b0, memReq}, 32'd0);
        checkOutput("reset rsp_rdata", rspRdata, 32'd0);
        resetN = 1'b1;
        repeat (2) @(negedge clock);
        checkOutput("post-reset req_ready", {31'b0, reqReady}, 32'd1);

        //             id we   f3     addr          wdata         mdata         gd rd cmd be       cmdWdata      rsp rdata         err  lat
        applyStimulus(1,  1'b0, F3_B,  32'h0000_0103, 32'h0,        32'h80FF_1234, 0, 0, 1'b1, 4'b1000, 32'h0,        1'b1, 32'hFFFF_FF80, 1'b0, 3);
        repeat (3) @(negedge clock);
        checkOutput("vec1 rsp_rdata held", rspRdata, 32'hFFFF_FF80);
        applyStimulus(2,  1'b0, F3_HU, 32'h0000_0102, 32'h0,        32'h8001_0000, 0, 0, 1'b1, 4'b1100, 32'h0,        1'b1, 32'h0000_8001, 1'b0, 3);
        applyStimulus(3,  1'b1, F3_H,  32'h0000_0202, 32'h0000_ABCD, 32'hDEAD_BEEF, 0, 0, 1'b1, 4'b1100, 32'hABCD_ABCD, 1'b1, 32'h0,        1'b0, 3);
        applyStimulus(4,  1'b0, F3_W,  32'h0000_0101, 32'h0,        32'h1111_1111, 0, 0, 1'b0, 4'b0000, 32'h0,        1'b1, 32'h0,        1'b1, 2);
        repeat (3) @(negedge clock);
        checkOutput("vec4 rsp_err held", {31'b0, rspErr}, 32'd1);
        applyStimulus(5,  1'b0, F3_B,  32'h0000_0001, 32'h0,        32'h0000_7F00, 0, 0, 1'b1, 4'b0010, 32'h0,        1'b1, 32'h0000_007F, 1'b0, 3);
        applyStimulus(6,  1'b0, F3_H,  32'h0000_0006, 32'h0,        32'h8765_0000, 0, 0, 1'b1, 4'b1100, 32'h0,        1'b1, 32'hFFFF_8765, 1'b0, 3);
        applyStimulus(7,  1'b0, F3_BU, 32'h0000_0002, 32'h0,        32'h00A5_0000, 0, 0, 1'b1, 4'b0100, 32'h0,        1'b1, 32'h0000_00A5, 1'b0, 3);
        applyStimulus(8,  1'b0, F3_W,  32'h0000_0008, 32'h0,        32'h1234_5678, 0, 0, 1'b1, 4'b1111, 32'h0,        1'b1, 32'h1234_5678, 1'b0, 3);
        applyStimulus(9,  1'b1, F3_B,  32'h0000_0011, 32'h0000_005A, 32'hDEAD_BEEF, 0, 0, 1'b1, 4'b0010, 32'h5A5A_5A5A, 1'b1, 32'h0,        1'b0, 3);
        applyStimulus(10, 1'b1, F3_W,  32'h0000_0020, 32'hCAFE_F00D, 32'hDEAD_BEEF, 0, 0, 1'b1, 4'b1111, 32'hCAFE_F00D, 1'b1, 32'h0,        1'b0, 3);
        applyStimulus(11, 1'b1, F3_BU, 32'h0000_0030, 32'h0000_0012, 32'h0,        0, 0, 1'b0, 4'b0000, 32'h0,        1'b1, 32'h0,        1'b1, 2);
        applyStimulus(12, 1'b0, 3'b011, 32'h0000_0040, 32'h0,       32'h0,        0, 0, 1'b0, 4'b0000, 32'h0,        1'b1, 32'h0,        1'b1, 2);
        applyStimulus(13, 1'b0, F3_H,  32'h0000_0003, 32'h0,        32'h0,        0, 0, 1'b0, 4'b0000, 32'h0,        1'b1, 32'h0,        1'b1, 2);
        applyStimulus(14, 1'b0, F3_B,  32'h0000_0000, 32'h0,        32'h0000_00FF, 2, 1, 1'b1, 4'b0001, 32'h0,        1'b1, 32'hFFFF_FFFF, 1'b0, 6);

        // Grant withheld: the memory model stays silent
        memEnable = 1'b0;
`ifdef LSU_TIMEOUT_EN
        applyStimulus(15, 1'b0, F3_W,  32'h0000_0040, 32'h0,        32'h0,        0, 0, 1'b1, 4'b1111, 32'h0,        1'b1, 32'h0,        1'b1, 17);
        repeat (2) @(negedge clock);
        checkOutput("timeout busy cleared", {31'b0, busy}, 32'd0);
        checkOutput("timeout mem_req dropped", {31'b0, memReq}, 32'd0);
`else
        applyStimulus(15, 1'b0, F3_W,  32'h0000_0040, 32'h0,        32'h0,        0, 0, 1'b1, 4'b1111, 32'h0,        1'b0, 32'h0,        1'b0, 0);
        repeat (20) @(negedge clock);
        checkOutput("stall busy", {31'b0, busy}, 32'd1);
        checkOutput("stall mem_req", {31'b0, memReq}, 32'd1);
        resetN = 1'b0;
        #1;
        checkOutput("stall reset mem_req", {31'b0, memReq}, 32'd0);
        checkOutput("stall reset busy", {31'b0, busy}, 32'd0);
        @(negedge clock);
        resetN = 1'b1;
        repeat (3) @(negedge clock);
`endif
        memEnable = 1'b1;

        // Reset pulse while waiting for the memory response; rvalid arrives after release
        applyStimulus(16, 1'b0, F3_W,  32'h0000_0050, 32'h0,        32'h7777_7777, 0, 3, 1'b1, 4'b1111, 32'h0,        1'b0, 32'h0,        1'b0, 0);
        repeat (3) @(negedge clock);
        checkOutput("mid-wait busy", {31'b0, busy}, 32'd1);
        resetN = 1'b0;
        #1;
        checkOutput("mid-wait reset busy", {31'b0, busy}, 32'd0);
        checkOutput("mid-wait reset req_ready", {31'b0, reqReady}, 32'd0);
        checkOutput("mid-wait reset rsp_valid", {31'b0, rspValid}, 32'd0);
        @(negedge clock);
        resetN = 1'b1;
        repeat (4) @(negedge clock);
        checkOutput("after reset req_ready", {31'b0, reqReady}, 32'd1);
        checkOutput("after reset busy", {31'b0, busy}, 32'd0);

        applyStimulus(17, 1'b0, F3_W,  32'h0000_0030, 32'h0,        32'h0BAD_F00D, 0, 0, 1'b1, 4'b1111, 32'h0,        1'b1, 32'h0BAD_F00D, 1'b0, 3);

        repeat (5) @(negedge clock);
        checkOutput("command queue drained", cmdQ.size(), 32'd0);
        checkOutput("response queue drained", rspQ.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
